// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer for the single square-wave voice: arbitrates event pulses by
// fixed priority and steps through per-event note lists, driving the synth period/enable.
module sfx_sequencer #(
    parameter int TICK_UNIT = 256,
    parameter int GAP_TICKS = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        SAMPLE_TRIGGER,
    input  logic [3:0]  EVENT_REQ,
    input  logic        MUTE,
    output logic [15:0] HALF_PERIOD,
    output logic        SYNTH_ENABLE,
    output logic        BUSY,
    output logic [1:0]  ACTIVE_EVENT,
    output logic [3:0]  EVENT_ACK
);

    localparam int DUR_W = 8 + $clog2(TICK_UNIT);
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Note table: {half_period, duration units}; a zero duration ends the sequence.
    function automatic logic [23:0] rom_entry(input logic [1:0] ev, input logic [2:0] idx);
        logic [23:0] e;
        e = '0;
        case ({ev, idx})
            5'b00_000: e = {16'd100, 8'd4};
            5'b01_000: e = {16'd150, 8'd2};
            5'b10_000: e = {16'd80,  8'd2};
            5'b10_001: e = {16'd60,  8'd2};
            5'b11_000: e = {16'd200, 8'd8};
            5'b11_001: e = {16'd250, 8'd8};
            5'b11_010: e = {16'd300, 8'd8};
            5'b11_011: e = {16'd400, 8'd16};
            default:   e = '0;
        endcase
        return e;
    endfunction

    logic [1:0]       state, state_n;
    logic [1:0]       active_n;
    logic [2:0]       note_idx, note_n;
    logic [DUR_W-1:0] dur_cnt, dur_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [15:0]      hp_n;
    logic [3:0]       ack_n;
    logic             en_n;

    logic [1:0]  req_idx;
    logic        req_any;
    logic [23:0] rom_word;
    logic [15:0] rom_hp;
    logic [7:0]  rom_dur;
    logic        seq_done;
    logic        accept;

    always_comb begin
        req_idx = 2'd0;
        if (EVENT_REQ[3])      req_idx = 2'd3;
        else if (EVENT_REQ[2]) req_idx = 2'd2;
        else if (EVENT_REQ[1]) req_idx = 2'd1;
        else                   req_idx = 2'd0;
    end

    assign req_any  = |EVENT_REQ;
    assign rom_word = rom_entry(ACTIVE_EVENT, note_idx);
    assign rom_hp   = rom_word[23:8];
    assign rom_dur  = rom_word[7:0];
    // A sequence about to terminate counts as idle, so a request arriving then starts without a gap.
    assign seq_done = (state == ST_LOAD) && ((rom_dur == 8'd0) || (note_idx == 3'd4));
    assign accept   = req_any && ((state == ST_IDLE) || seq_done || (req_idx > ACTIVE_EVENT));

    always_comb begin
        state_n  = state;
        active_n = ACTIVE_EVENT;
        note_n   = note_idx;
        dur_n    = dur_cnt;
        gap_n    = gap_cnt;
        hp_n     = HALF_PERIOD;
        ack_n    = 4'b0000;
        if (accept) begin
            state_n  = ST_LOAD;
            active_n = req_idx;
            note_n   = 3'd0;
            dur_n    = '0;
            gap_n    = '0;
            ack_n    = 4'b0001 << req_idx;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (seq_done) begin
                        state_n = ST_IDLE;
                    end else begin
                        hp_n    = rom_hp;
                        dur_n   = DUR_W'(rom_dur) * DUR_W'(TICK_UNIT);
                        state_n = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (SAMPLE_TRIGGER) begin
                        if (dur_cnt == DUR_W'(1)) begin
                            dur_n  = '0;
                            note_n = note_idx + 3'd1;
                            if (GAP_TICKS > 0) begin
                                gap_n   = '0;
                                state_n = ST_GAP;
                            end else begin
                                state_n = ST_LOAD;
                            end
                        end else begin
                            dur_n = dur_cnt - DUR_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (SAMPLE_TRIGGER) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_n   = '0;
                            state_n = ST_LOAD;
                        end else begin
                            gap_n = gap_cnt + GAP_W'(1);
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        en_n = (state_n == ST_PLAY) && !MUTE;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_IDLE;
            ACTIVE_EVENT <= 2'd0;
            note_idx     <= 3'd0;
            dur_cnt      <= '0;
            gap_cnt      <= '0;
            HALF_PERIOD  <= 16'd0;
            EVENT_ACK    <= 4'b0000;
            SYNTH_ENABLE <= 1'b0;
        end else begin
            state        <= state_n;
            ACTIVE_EVENT <= active_n;
            note_idx     <= note_n;
            dur_cnt      <= dur_n;
            gap_cnt      <= gap_n;
            HALF_PERIOD  <= hp_n;
            EVENT_ACK    <= ack_n;
            SYNTH_ENABLE <= en_n;
        end
    end

    assign BUSY = (state != ST_IDLE);

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Sound-effect controller for the game's single square-wave voice.
- Accepts one-cycle event pulses from game logic (paddle hit, wall hit, brick hit, life lost) and arbitrates them by fixed priority.
- Plays the selected event's note sequence from an internal ROM by driving the synth's HALF_PERIOD and ENABLE inputs.
- Times note durations in SAMPLE_TRIGGER ticks shared with the synth.

Parameters:
- TICK_UNIT, 256: SAMPLE_TRIGGER ticks per duration unit; must be ≥ 1.
- GAP_TICKS, 8: SAMPLE_TRIGGER ticks of silence between consecutive notes; 0 means no gap.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- SAMPLE_TRIGGER  in  1  one-cycle sample strobe, same signal as fed to the synth.
- EVENT_REQ  in  4  one-cycle request pulses. Bit 0 paddle, 1 wall, 2 brick, 3 life lost.
- MUTE  in  1  level; silences output while sequencing continues.
- HALF_PERIOD  out  16  to synth HALF_PERIOD.
- SYNTH_ENABLE  out  1  to synth ENABLE.
- BUSY  out  1  high whenever state ≠ IDLE.
- ACTIVE_EVENT  out  2  index of event being played; holds last value when idle.
- EVENT_ACK  out  4  one-cycle pulse on the accepted request bit.

Behaviour:
- Reset (async, RESET_N low):
  - state IDLE; all outputs 0.
  - Duration, gap and note-index counters cleared.
  - Reset is honoured at any time, including mid-note; playback does not resume.
- ROM: each entry is {half_period[15:0], dur[7:0]}, up to 4 notes per event. dur = 0 terminates the sequence.
  - Event 0: (100, 4)
  - Event 1: (150, 2)
  - Event 2: (80, 2), (60, 2)
  - Event 3: (200, 8), (250, 8), (300, 8), (400, 16)
- Priority: higher bit index wins. Several simultaneous EVENT_REQ bits → only the highest is accepted; the others are dropped.
- Acceptance:
  - In IDLE, any request is accepted.
  - When not IDLE, a request is accepted only if its index > ACTIVE_EVENT (preemption).
  - An equal- or lower-priority request while BUSY is dropped with no ACK.
- Accept timing:
  - Request sampled high at edge N.
  - At edge N: EVENT_ACK[i] = 1 for one cycle, ACTIVE_EVENT = i, note index = 0, state LOAD, SYNTH_ENABLE = 0.
- States:
  - LOAD (1 cycle): read ROM[event][note].
    - dur = 0 or note index = 4 → IDLE (SYNTH_ENABLE stays 0).
    - Otherwise latch HALF_PERIOD, load the duration counter with dur·TICK_UNIT, go to PLAY. SYNTH_ENABLE = 1 from the next cycle unless MUTE.
  - PLAY:
    - Each SAMPLE_TRIGGER decrements the duration counter (width ≥ 8 + log2(TICK_UNIT)).
    - On a trigger with counter = 1: note index +1. If GAP_TICKS > 0 go to GAP with SYNTH_ENABLE = 0; else go to LOAD.
  - GAP:
    - SYNTH_ENABLE = 0; GAP_TICKS SAMPLE_TRIGGER pulses are counted.
    - On the last one, go to LOAD.
    - The gap guarantees the synth's internal tick restarts at 0 for the next note.
  - IDLE: SYNTH_ENABLE = 0. HALF_PERIOD holds its last value (don't-care to the synth).
- SYNTH_ENABLE is registered = (state == PLAY) && !MUTE. MUTE toggling does not stall the counters.
- Preemption at any state (LOAD, PLAY, GAP):
  - Behaves as acceptance from IDLE: counters cleared, SYNTH_ENABLE low for at least the LOAD cycle.
- Request coinciding with the final note ending: the request is processed first; the new sequence starts and there is no idle cycle.
- SAMPLE_TRIGGER in the same cycle as the ACK is ignored; duration counting starts in PLAY.
- No wrap-around: dur · TICK_UNIT ≤ 255·TICK_UNIT fits the counter.

Test Plan (bench: TICK_UNIT = 4, GAP_TICKS = 2, SAMPLE_TRIGGER every 3 cycles):
1. Pulse EVENT_REQ = 0001 from IDLE:
   - EVENT_ACK = 0001 next cycle; HALF_PERIOD = 100 and SYNTH_ENABLE = 1 two cycles after the request.
   - SYNTH_ENABLE high for exactly 16 SAMPLE_TRIGGERs, then 2-trigger gap, then BUSY = 0.
2. EVENT_REQ = 0100 (brick):
   - HALF_PERIOD 80 for 8 triggers, low for 2 triggers, HALF_PERIOD 60 for 8 triggers, then IDLE.
   - ACTIVE_EVENT = 2 throughout.
3. Simultaneous EVENT_REQ = 1011 in IDLE:
   - Only EVENT_ACK[3] pulses; ACTIVE_EVENT = 3; four notes 200/250/300/400 with lengths 32/32/32/64 triggers.
4. During event 2 playback, pulse EVENT_REQ[0] → no ACK, playback unchanged. Then pulse EVENT_REQ[3] mid-note:
   - ACK[3]; SYNTH_ENABLE drops for ≥ 1 cycle; HALF_PERIOD = 200.
5. Assert MUTE during event 1:
   - SYNTH_ENABLE = 0 while BUSY stays 1; BUSY falls at the same cycle as the unmuted run.
   - Releasing MUTE mid-note re-enables the synth next cycle.
6. Drop RESET_N mid-PLAY of event 3, asynchronously (not on a clock edge):
   - All outputs 0 immediately; after release, IDLE with no spontaneous playback.
   - A new EVENT_REQ[1] plays HALF_PERIOD 150 normally.
